// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio front-end (FIR -> frame buffer -> FFT).
//   sample_t         : signed sample as produced by the FIR stage
//   DEF_DECIM        : default decimation factor of the frame buffer
//   DEF_FRAME_LEN    : default samples per frame handed to the FFT
//   frame_rd_state_t : frame reader FSM states
package audio_pkg;
  localparam int SAMPLE_W      = 9;
  localparam int DEF_DECIM     = 4;
  localparam int DEF_FRAME_LEN = 256;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } frame_rd_state_t;
endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks.
// Address is {bank, addr}. Registered read with 1-cycle latency so it maps
// onto block RAM; contents are never reset.
//   clk_in  : clock
//   wr_en / wr_addr / wr_data : write port
//   rd_en / rd_addr / rd_data : read port, rd_data updates only when rd_en
module frame_bank_ram #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 9
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Writer and reader never touch the same bank at once, so no
  // read-during-write ordering matters here.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/audio_frame_buffer.sv
// Decimating ping-pong frame buffer between the FIR and the FFT stage.
// Keeps one of every DECIM input samples, packs kept samples into
// FRAME_LEN-sample frames across two banks, and streams complete frames out
// over valid/ready.
//   clk_in, rst_n_in : clock, async active-low reset
//   audio_in, valid_in : filtered sample and its one-cycle strobe
//   m_data, m_valid, m_ready, m_last : frame stream to the FFT
//   overflow : one-cycle pulse per kept sample dropped (both banks full)
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_W,
  parameter int DECIM     = DEF_DECIM,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic signed [WIDTH-1:0] audio_in,
  input  logic                    valid_in,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    overflow
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);

  logic [PW-1:0]   phase;
  logic            wr_bank, rd_bank;
  logic [AW-1:0]   wr_addr, rd_addr, rd_addr_mux;
  logic [1:0]      full;
  frame_rd_state_t state;
  logic            keep, wr_en, rd_en, hs, frame_done, frame_free;
  logic [WIDTH-1:0] ram_q;

  assign keep       = valid_in && (phase == '0);
  assign wr_en      = keep && !full[wr_bank];
  assign frame_done = wr_en && (wr_addr == LAST_ADDR);
  assign hs         = m_valid && m_ready;
  assign frame_free = (state == STREAM) && hs && m_last;

  // rd_addr already points one ahead of the sample on m_data; a new read is
  // issued only when the current sample is consumed, so the RAM output
  // register doubles as the output holding register under backpressure.
  assign rd_en       = (state == FETCH) || ((state == STREAM) && hs && !m_last);
  assign rd_addr_mux = (state == FETCH) ? '0 : rd_addr;

  // RAM output is not reset; gating keeps m_data at 0 whenever not valid.
  assign m_data = m_valid ? ram_q : '0;

  frame_bank_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_addr}),
    .wr_data (audio_in),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_addr_mux}),
    .rd_data (ram_q)
  );

  // Decimator and writer. A dropped sample still advances the phase but
  // leaves wr_addr untouched.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase    <= '0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= keep && full[wr_bank];
      if (valid_in) phase <= (phase == LAST_PHASE) ? '0 : phase + PW'(1);
      if (wr_en) begin
        if (wr_addr == LAST_ADDR) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + AW'(1);
        end
      end
    end
  end

  // Writer only sets a bank it owns (not full), reader only clears the bank
  // it is draining (full), so the two updates never collide.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      full <= 2'b00;
    end else begin
      if (frame_done) full[wr_bank] <= 1'b1;
      if (frame_free) full[rd_bank] <= 1'b0;
    end
  end

  // Reader FSM.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (full[rd_bank]) state <= FETCH;
        FETCH: begin
          rd_addr <= AW'(1);
          m_valid <= 1'b1;
          m_last  <= 1'b0;
          state   <= STREAM;
        end
        STREAM: if (hs) begin
          if (m_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            rd_bank <= ~rd_bank;
            state   <= IDLE;
          end else begin
            m_last  <= (rd_addr == LAST_ADDR);
            rd_addr <= rd_addr + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_frame_buffer.sv
module tb_audio_frame_buffer;
  localparam int DECIM = 4;
  localparam int FL    = 8;
  localparam int W     = 9;

  typedef logic signed [W-1:0] smp_t;
  typedef struct { smp_t din; smp_t dout; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  smp_t audio_in = '0;
  logic valid_in = 1'b0;
  logic m_ready = 1'b0;
  smp_t m_data;
  logic m_valid, m_last, overflow;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  audio_frame_buffer #(.WIDTH(W), .DECIM(DECIM), .FRAME_LEN(FL)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .audio_in (audio_in),
    .valid_in (valid_in),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: kept samples gather into a partial frame; a finished
  // frame joins the expected output stream. At most two frames may be held
  // (completed but not fully consumed); a kept sample arriving then is lost.
  smp_t partial[$];
  smp_t expq[$];
  smp_t got_q[$];
  int   phase_m = 0;
  int   held = 0;
  int   out_idx = 0;
  bit   exp_ovf = 0;
  int   cd = 0;
  int   hs_cnt = 0, ovf_cnt = 0, last_cnt = 0;
  logic pv_valid = 0, pv_ready = 0, pv_last = 0;
  smp_t pv_data = '0;
  smp_t e;
  bit   hs_now, exp_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial.delete(); expq.delete();
      phase_m = 0; held = 0; out_idx = 0; exp_ovf = 0; cd = 0;
      pv_valid = 0; pv_ready = 0; pv_last = 0; pv_data = '0;
    end else begin
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (pv_valid && !pv_ready) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(pv_data));
        check("hold_last", 32'(m_last), 32'(pv_last));
      end
      if (cd > 0) begin
        cd--;
        check("first_valid_latency", 32'(m_valid), (cd == 0) ? 32'd1 : 32'd0);
      end
      hs_now = m_valid && m_ready;
      exp_last = 0;
      if (hs_now) begin
        hs_cnt++;
        if (m_last) last_cnt++;
        got_q.push_back(m_data);
        if (expq.size() == 0) begin
          check("unexpected_output", 32'(m_data), 32'hDEAD);
        end else begin
          e = expq.pop_front();
          exp_last = (out_idx == FL - 1);
          check("out_data", 32'(m_data), 32'(e));
          check("out_last", 32'(m_last), 32'(exp_last));
          out_idx = (out_idx + 1) % FL;
        end
      end
      exp_ovf = 0;
      if (valid_in) begin
        if (phase_m == 0) begin
          if (held == 2) exp_ovf = 1;
          else begin
            partial.push_back(audio_in);
            if (partial.size() == FL) begin
              if (held == 0) cd = 3;
              held++;
              foreach (partial[i]) expq.push_back(partial[i]);
              partial.delete();
            end
          end
        end
        phase_m = (phase_m + 1) % DECIM;
      end
      if (hs_now && exp_last) held--;
      if (overflow) ovf_cnt++;
      pv_valid = m_valid; pv_ready = m_ready; pv_last = m_last; pv_data = m_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic v, input smp_t d, input logic r);
    @(negedge clk);
    valid_in = v; audio_in = d; m_ready = r;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; valid_in = 0; audio_in = '0; m_ready = 0;
    #1 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    valid_in = 0;
    #1 check_zero_outputs(tag);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  vec_t tbl[8];
  int h0, o0, l0, n, guard;
  logic v;

  initial begin
    tbl[0] = '{smp_t'(-1),   smp_t'(9'h1FF)};
    tbl[1] = '{smp_t'(-256), smp_t'(9'h100)};
    tbl[2] = '{smp_t'(255),  smp_t'(9'h0FF)};
    tbl[3] = '{smp_t'(0),    smp_t'(9'h000)};
    tbl[4] = '{smp_t'(1),    smp_t'(9'h001)};
    tbl[5] = '{smp_t'(-2),   smp_t'(9'h1FE)};
    tbl[6] = '{smp_t'(-128), smp_t'(9'h180)};
    tbl[7] = '{smp_t'(127),  smp_t'(9'h07F)};

    // Basic frame: valid every 3rd cycle.
    do_reset();
    h0 = hs_cnt; o0 = ovf_cnt; l0 = last_cnt; got_q.delete();
    for (int i = 0; i < 32; i++) begin
      tick(1, smp_t'(i), 1);
      tick(0, '0, 1);
      tick(0, '0, 1);
    end
    repeat (20) tick(0, '0, 1);
    check("basic_count", 32'(hs_cnt - h0), 32'd8);
    check("basic_last_count", 32'(last_cnt - l0), 32'd1);
    check("basic_no_overflow", 32'(ovf_cnt - o0), 32'd0);
    check("basic_last_value", (got_q.size() == 8) ? 32'(got_q[7]) : 32'hFFFF, 32'(smp_t'(28)));

    // Back-to-back input.
    do_reset();
    h0 = hs_cnt; got_q.delete();
    for (int i = 0; i < 64; i++) tick(1, smp_t'(i), 1);
    repeat (20) tick(0, '0, 1);
    check("b2b_count", 32'(hs_cnt - h0), 32'd16);
    check("b2b_second_frame_first", (got_q.size() == 16) ? 32'(got_q[8]) : 32'hFFFF, 32'(smp_t'(32)));

    // Sign handling, table driven.
    do_reset();
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      tick(1, tbl[i].din, 1);
      repeat (3) tick(1, smp_t'(9'h0AA), 1);
    end
    repeat (20) tick(0, '0, 1);
    check("sign_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("sign_vec%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(tbl[i].dout));

    // Backpressure: random ready ~30 %, random valid, 5 frames.
    do_reset();
    h0 = hs_cnt; o0 = ovf_cnt;
    n = 0; guard = 0;
    while (n < 5 * FL * DECIM && guard < 5000) begin
      v = ($urandom % 2) == 1;
      tick(v, smp_t'($urandom), ($urandom % 10) < 3);
      if (v) n++;
      guard++;
    end
    guard = 0;
    while ((expq.size() != 0 || m_valid) && guard < 1000) begin
      tick(0, '0, ($urandom % 10) < 3);
      guard++;
    end
    tick(0, '0, 0);
    check("bp_drained", 32'(expq.size()), 32'd0);
    check("bp_delivered_plus_dropped", 32'((hs_cnt - h0) + (ovf_cnt - o0)), 32'd40);

    // Overflow: consumer stalled for three frames of kept samples.
    do_reset();
    h0 = hs_cnt; o0 = ovf_cnt; got_q.delete();
    for (int i = 0; i < 96; i++) tick(1, smp_t'(i), 0);
    repeat (3) tick(0, '0, 0);
    check("ovf_pulses", 32'(ovf_cnt - o0), 32'd8);
    repeat (40) tick(0, '0, 1);
    check("ovf_drain_count", 32'(hs_cnt - h0), 32'd16);
    check("ovf_drain_tail", (got_q.size() == 16) ? 32'(got_q[15]) : 32'hFFFF, 32'(smp_t'(60)));

    // Async reset mid-stream, after 3 of 8 outputs.
    do_reset();
    h0 = hs_cnt;
    for (int i = 0; i < 32; i++) tick(1, smp_t'(i), 1);
    tick(0, '0, 1);
    guard = 0;
    while ((hs_cnt - h0) < 3 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("midstream_reached", 32'(hs_cnt - h0), 32'd3);
    async_reset("midstream");

    // Async reset mid-fill, then a clean frame.
    for (int i = 0; i < 12; i++) tick(1, smp_t'(300 + i), 1);
    async_reset("midfill");
    h0 = hs_cnt; got_q.delete();
    for (int i = 0; i < 32; i++) tick(1, smp_t'(400 + i), 1);
    repeat (20) tick(0, '0, 1);
    check("after_reset_count", 32'(hs_cnt - h0), 32'd8);
    check("after_reset_first", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF, 32'(smp_t'(400)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end
endmodule
